// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: N masters share one slave port.
// Grant is held for a whole cyc; a watchdog aborts unacked strobes.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int BUS_DATA_WIDTH = 32,
  parameter int BUS_ADDR_WIDTH = 8,
  parameter int BUS_BE_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                  wb_clk_i,
  input  logic                                  wb_rst_n_i,
  input  logic [NUM_MASTERS-1:0]                m_cyc_i,
  input  logic [NUM_MASTERS-1:0]                m_stb_i,
  input  logic [NUM_MASTERS-1:0]                m_we_i,
  input  logic [NUM_MASTERS*BUS_BE_WIDTH-1:0]   m_sel_i,
  input  logic [NUM_MASTERS*BUS_ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*BUS_DATA_WIDTH-1:0] m_dat_i,
  output logic [BUS_DATA_WIDTH-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]                m_ack_o,
  output logic [NUM_MASTERS-1:0]                m_err_o,
  output logic                                  s_cyc_o,
  output logic                                  s_stb_o,
  output logic                                  s_we_o,
  output logic [BUS_BE_WIDTH-1:0]               s_sel_o,
  output logic [BUS_ADDR_WIDTH-1:0]             s_adr_o,
  output logic [BUS_DATA_WIDTH-1:0]             s_dat_o,
  input  logic [BUS_DATA_WIDTH-1:0]             s_dat_i,
  input  logic                                  s_ack_i,
  output logic [NUM_MASTERS-1:0]                grant_o,
  output logic                                  busy_o
);

  localparam int IW  = $clog2(NUM_MASTERS);
  localparam int WDW = (TIMEOUT_CYCLES > 0) ?
                       $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST =
    WDW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    ERR,
    WAIT_DROP
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          gidx_q, gidx_d;
  logic [IW-1:0]          last_q, last_d;
  logic [WDW-1:0]         wd_q, wd_d;
  logic                   busy_q, busy_d;

  logic                   win_vld;
  logic [IW-1:0]          win_idx;
  logic [IW-1:0]          cand;
  int                     idx;
  logic                   g_cyc;
  logic                   g_stb;
  logic                   active;

  // Rotating priority search starting just after the last owner
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    cand    = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = int'(last_q) + i;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      cand = IW'(idx);
      if (!win_vld && m_cyc_i[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign g_cyc  = m_cyc_i[gidx_q];
  assign g_stb  = m_stb_i[gidx_q];
  assign active = (state_q == ACTIVE);

  assign s_cyc_o = active & g_cyc;
  assign s_stb_o = active & g_stb;
  assign s_we_o  = active & m_we_i[gidx_q];
  assign s_sel_o = active ?
    m_sel_i[int'(gidx_q)*BUS_BE_WIDTH +: BUS_BE_WIDTH] : '0;
  assign s_adr_o = active ?
    m_adr_i[int'(gidx_q)*BUS_ADDR_WIDTH +: BUS_ADDR_WIDTH] : '0;
  assign s_dat_o = active ?
    m_dat_i[int'(gidx_q)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] : '0;
  assign m_dat_o = active ? s_dat_i : '0;
  assign m_ack_o = active ? (grant_q & {NUM_MASTERS{s_ack_i}}) : '0;
  assign m_err_o = (state_q == ERR) ? grant_q : '0;
  assign grant_o = grant_q;
  assign busy_o  = busy_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    wd_d    = wd_q;
    unique case (state_q)
      IDLE: begin
        wd_d = '0;
        if (win_vld) begin
          state_d = ACTIVE;
          gidx_d  = win_idx;
          grant_d = NUM_MASTERS'(1) << win_idx;
        end
      end
      ACTIVE: begin
        if (!g_cyc) begin
          state_d = IDLE;
          last_d  = gidx_q;
          grant_d = '0;
          wd_d    = '0;
        end else if (TIMEOUT_CYCLES > 0 && g_stb && !s_ack_i) begin
          if (wd_q == WD_LAST) begin
            state_d = ERR;
            wd_d    = '0;
          end else begin
            wd_d = wd_q + WDW'(1);
          end
        end else begin
          wd_d = '0;
        end
      end
      ERR, WAIT_DROP: begin
        if (!g_cyc) begin
          state_d = IDLE;
          last_d  = gidx_q;
          grant_d = '0;
        end else begin
          state_d = WAIT_DROP;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= LAST_RST;
      wd_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: arbitration order, hold,
// watchdog abort, ack-vs-timeout race and async reset.
module tb_wb_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int BW = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    cyc, stb, we;
  logic [N*BW-1:0] sel;
  logic [N*AW-1:0] adr;
  logic [N*DW-1:0] wdat;
  logic [DW-1:0]   m_dat;
  logic [N-1:0]    m_ack, m_err;
  logic            s_cyc, s_stb, s_we;
  logic [BW-1:0]   s_sel;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_wdat;
  logic [DW-1:0]   s_rdat;
  logic            s_ack;
  logic [N-1:0]    grant;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int ord[5] = '{0, 1, 2, 3, 0};

  always #5 clk = ~clk;

  wb_rr_arbiter #(
    .NUM_MASTERS(N), .BUS_DATA_WIDTH(DW), .BUS_ADDR_WIDTH(AW),
    .BUS_BE_WIDTH(BW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we),
    .m_sel_i(sel), .m_adr_i(adr), .m_dat_i(wdat),
    .m_dat_o(m_dat), .m_ack_o(m_ack), .m_err_o(m_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
    .s_sel_o(s_sel), .s_adr_o(s_adr), .s_dat_o(s_wdat),
    .s_dat_i(s_rdat), .s_ack_i(s_ack),
    .grant_o(grant), .busy_o(busy)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    cyc    = '0;
    stb    = '0;
    we     = '0;
    sel    = '1;
    adr    = '0;
    wdat   = '0;
    s_rdat = 32'h55AA_55AA;
    s_ack  = 1'b1;
    #12;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_cyc", s_cyc, 0);
    chk("rst_s_stb", s_stb, 0);
    chk("rst_ack", m_ack, 0);
    chk("rst_err", m_err, 0);
    chk("rst_mdat", m_dat, 0);
    chk("rst_s_adr", s_adr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // all four request continuously, one transfer per grant
    step();
    cyc = '1;
    stb = '1;
    mid();
    chk("rr_idle0", busy, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      mid();
      chk("rr_grant", grant, 64'(1) << ord[k]);
      chk("rr_busy", busy, 1);
      chk("rr_ack", m_ack, 64'(1) << ord[k]);
      cyc[ord[k]] = 1'b0;
      stb[ord[k]] = 1'b0;
      step();
      mid();
      chk("rr_gap_busy", busy, 0);
      chk("rr_gap_grant", grant, 0);
      cyc[ord[k]] = 1'b1;
      stb[ord[k]] = 1'b1;
    end
    cyc   = '0;
    stb   = '0;
    s_ack = 1'b0;

    // single write from master 2
    step();
    cyc[2] = 1'b1;
    stb[2] = 1'b1;
    we[2]  = 1'b1;
    adr[2*AW +: AW] = 8'h10;
    wdat[2*DW +: DW] = 32'hDEAD_BEEF;
    mid();
    chk("m2_latency", grant, 0);
    step();
    mid();
    chk("m2_grant", grant, 4'b0100);
    chk("m2_s_cyc", s_cyc, 1);
    chk("m2_s_stb", s_stb, 1);
    chk("m2_s_we", s_we, 1);
    chk("m2_s_adr", s_adr, 8'h10);
    chk("m2_s_dat", s_wdat, 32'hDEAD_BEEF);
    chk("m2_s_sel", s_sel, 4'hF);
    chk("m2_ack_lo", m_ack, 0);
    step();
    s_ack = 1'b1;
    mid();
    chk("m2_ack_hi", m_ack, 4'b0100);
    step();
    s_ack  = 1'b0;
    cyc[2] = 1'b0;
    stb[2] = 1'b0;
    we     = '0;
    mid();
    chk("m2_ack_drop", m_ack, 0);
    chk("m2_s_cyc_drop", s_cyc, 0);
    step();
    mid();
    chk("m2_idle_grant", grant, 0);
    chk("m2_idle_busy", busy, 0);

    // master 1 burst of 3 reads while master 3 waits
    step();
    cyc[1] = 1'b1;
    stb[1] = 1'b1;
    step();
    cyc[3] = 1'b1;
    stb[3] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      adr[1*AW +: AW] = AW'(i);
      s_rdat = 32'hA0 + 32'(i);
      s_ack  = 1'b1;
      mid();
      chk("burst_grant", grant, 4'b0010);
      chk("burst_adr", s_adr, 64'(i));
      chk("burst_mdat", m_dat, 64'h A0 + 64'(i));
      chk("burst_ack", m_ack, 4'b0010);
      step();
    end
    cyc[1] = 1'b0;
    stb[1] = 1'b0;
    s_ack  = 1'b0;
    mid();
    chk("burst_hold", grant, 4'b0010);
    step();
    mid();
    chk("burst_gap", grant, 0);
    step();
    mid();
    chk("m3_grant", grant, 4'b1000);
    cyc[3] = 1'b0;
    stb[3] = 1'b0;
    step();

    // slave never acks: watchdog abort on master 0
    cyc[0] = 1'b1;
    stb[0] = 1'b1;
    step();
    for (int i = 1; i <= TO; i++) begin
      mid();
      chk("wd_no_err", m_err, 0);
      chk("wd_s_cyc", s_cyc, 1);
      step();
    end
    mid();
    chk("wd_err", m_err, 4'b0001);
    chk("wd_err_s_cyc", s_cyc, 0);
    chk("wd_err_s_stb", s_stb, 0);
    chk("wd_err_busy", busy, 1);
    step();
    mid();
    chk("wd_err_once", m_err, 0);
    chk("wd_wait_s_cyc", s_cyc, 0);
    chk("wd_wait_busy", busy, 1);
    cyc[0] = 1'b0;
    stb[0] = 1'b0;
    step();
    mid();
    chk("wd_idle_busy", busy, 0);
    chk("wd_idle_grant", grant, 0);

    // ack lands on the 16th wait cycle: ack wins
    cyc[1] = 1'b1;
    stb[1] = 1'b1;
    step();
    for (int i = 1; i < TO; i++) begin
      mid();
      chk("race_no_err", m_err, 0);
      step();
    end
    s_ack = 1'b1;
    mid();
    chk("race_ack", m_ack, 4'b0010);
    chk("race_err", m_err, 0);
    step();
    s_ack = 1'b0;
    mid();
    chk("race_err_after", m_err, 0);
    chk("race_busy", busy, 1);
    chk("race_s_cyc", s_cyc, 1);
    cyc[1] = 1'b0;
    stb[1] = 1'b0;
    step();
    mid();
    chk("race_idle", busy, 0);

    // async reset during a master 2 write
    cyc[2] = 1'b1;
    stb[2] = 1'b1;
    we[2]  = 1'b1;
    step();
    s_ack = 1'b1;
    mid();
    chk("rstm_grant_pre", grant, 4'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstm_grant", grant, 0);
    chk("rstm_s_cyc", s_cyc, 0);
    chk("rstm_busy", busy, 0);
    chk("rstm_ack", m_ack, 0);
    chk("rstm_err", m_err, 0);
    cyc[0] = 1'b1;
    stb[0] = 1'b1;
    s_ack  = 1'b0;
    step();
    chk("rstm_held", grant, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    mid();
    chk("rstm_prio0", grant, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
